// File: rtl/imem_uart_loader_pkg.sv
// rtl/imem_uart_loader_pkg.sv - shared types and constants for the UART instruction-memory loader
package imem_uart_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int BAUD_DIV_DEF = 868;
  localparam int UART_BYTE_W  = 8;

endpackage

// File: rtl/imem_uart_loader_rx.sv
// rtl/imem_uart_loader_rx.sv - 8N1 UART byte receiver with input synchronizer and mid-bit sampling
module uart_rx_byte
  import imem_uart_loader_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx,
  output logic [UART_BYTE_W-1:0] rx_tdata,
  output logic                   rx_tvalid,
  output logic                   frame_err
);

  localparam int CW = $clog2(BAUD_DIV);

  logic                   rx_m;
  logic                   rx_s;
  logic                   rx_q;
  rx_state_e              state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [UART_BYTE_W-1:0] shreg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_q      <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_tdata  <= '0;
      rx_tvalid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_q      <= rx_s;
      rx_tvalid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_q && !rx_s) begin
            state <= RX_START;
            cnt   <= CW'(BAUD_DIV / 2 - 1);
          end
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= RX_IDLE;
          end else begin
            state   <= RX_DATA;
            cnt     <= CW'(BAUD_DIV - 1);
            bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rx_s, shreg[UART_BYTE_W-1:1]};
            cnt     <= CW'(BAUD_DIV - 1);
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= RX_IDLE;
            if (rx_s) begin
              rx_tvalid <= 1'b1;
              rx_tdata  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - packs UART bytes into words and writes them into instruction memory
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int BAUD_DIV    = BAUD_DIV_DEF,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart_rx_i,
  input  logic              load_en_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              err_o
);

  localparam int              TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W:0] WMAX = (ADDR_W + 1)'(2 ** ADDR_W);

  logic [UART_BYTE_W-1:0] rx_tdata;
  logic                   rx_tvalid;
  logic                   frame_err;

  logic              len_m;
  logic              len_s;
  logic              len_q;
  ld_state_e         state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [31:0]       word_buf;
  logic [TW-1:0]     tcnt;
  logic              closing;

  uart_rx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (uart_rx_i),
    .rx_tdata (rx_tdata),
    .rx_tvalid(rx_tvalid),
    .frame_err(frame_err)
  );

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_m        <= 1'b0;
      len_s        <= 1'b0;
      len_q        <= 1'b0;
      state        <= ST_IDLE;
      addr         <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      tcnt         <= '0;
      closing      <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      cpu_rstn_o   <= 1'b1;
      word_cnt_o   <= '0;
      err_o        <= 1'b0;
    end else begin
      len_m      <= load_en_i;
      len_s      <= len_m;
      len_q      <= len_s;
      imem_we_o  <= 1'b0;
      cpu_rstn_o <= (state == ST_IDLE) && !len_s;
      case (state)
        ST_IDLE: begin
          if (len_s && !len_q) begin
            state      <= ST_LOAD;
            addr       <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            tcnt       <= '0;
            closing    <= 1'b0;
            word_cnt_o <= '0;
            err_o      <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Switch-off wins over any byte arriving in the same cycle.
          if (!len_s) begin
            if (byte_idx != 2'd0) begin
              state   <= ST_COMMIT;
              closing <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (frame_err) begin
            err_o <= 1'b1;
          end else if (rx_tvalid) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= rx_tdata;
            tcnt     <= '0;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) state <= ST_COMMIT;
          end else if (byte_idx != 2'd0) begin
            if (tcnt == TW'(TIMEOUT_CYC - 1)) state <= ST_COMMIT;
            else tcnt <= tcnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          if (word_cnt_o == WMAX) begin
            err_o <= 1'b1;
          end else begin
            imem_we_o    <= 1'b1;
            imem_addr_o  <= addr;
            imem_wdata_o <= word_buf;
            word_cnt_o   <= word_cnt_o + 1'b1;
            if (addr != {ADDR_W{1'b1}}) addr <= addr + 1'b1;
          end
          byte_idx <= '0;
          tcnt     <= '0;
          word_buf <= '0;
          closing  <= 1'b0;
          state    <= closing ? ST_IDLE : ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
